// File: rtl/mlcd_bus_ctrl.sv
// 8080-style MCU-LCD bus controller: paced write/read cycles, read word held for PIO in_port.
// Ports: cmd_* handshake in, rsp_valid/rdata/busy out, lcd_* bus pins. Macro: MLCD_RD_SYNC_EN.
module mlcd_bus_ctrl #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned WR_HIGH_CYC = 2,
  parameter int unsigned RD_LOW_CYC  = 4,
  parameter int unsigned RD_HIGH_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic        cmd_rs,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_dout,
  output logic        lcd_doe,
  input  logic [15:0] lcd_din
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STRB_LO,
    STRB_HI
  } state_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] SU_N = 8'(SETUP_CYC - 1);
  localparam logic [7:0] WL_N = 8'(WR_LOW_CYC - 1);
  localparam logic [7:0] WH_N = 8'(WR_HIGH_CYC - 1);
  localparam logic [7:0] RL_N = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] RH_N = 8'(RD_HIGH_CYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        rw_lat;
  logic        accept;
  logic        capture;
  logic        done;
  logic [15:0] sample;

`ifdef MLCD_RD_SYNC_EN
  logic [15:0] din_s1;
  logic [15:0] din_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      din_s1 <= '0;
      din_s2 <= '0;
    end else begin
      din_s1 <= lcd_din;
      din_s2 <= din_s1;
    end
  end

  assign sample = din_s2;
`else
  assign sample = lcd_din;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = SU_N;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = STRB_LO;
          cnt_nxt   = rw_lat ? RL_N : WL_N;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      STRB_LO: begin
        if (cnt == 8'd0) begin
          state_nxt = STRB_HI;
          cnt_nxt   = rw_lat ? RH_N : WH_N;
          capture   = rw_lat;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      STRB_HI: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // dout only loads on write acceptance so the bus value is
  // retained across reads while the driver is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_lat    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_dout  <= '0;
      rdata     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= done & rw_lat;
      if (accept) begin
        rw_lat <= cmd_rw;
        lcd_rs <= cmd_rs;
        if (!cmd_rw) begin
          lcd_dout <= cmd_wdata;
        end
      end
      if (capture) begin
        rdata <= sample;
      end
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign lcd_cs_n  = cmd_ready;
  assign lcd_doe   = busy & ~rw_lat;
  assign lcd_wr_n  = ~((state == STRB_LO) & ~rw_lat);
  assign lcd_rd_n  = ~((state == STRB_LO) & rw_lat);

endmodule

// File: tb/tb_mlcd_bus_ctrl.sv
// Self-checking bench for mlcd_bus_ctrl: vector table of single
// transactions plus back-to-back, reset-abort, sampling and min-timing sequences.
module tb_mlcd_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_valid1;
  logic        cmd_rw;
  logic        cmd_rs;
  logic [15:0] cmd_wdata;
  logic [15:0] lcd_din;

  logic        cmd_ready, rsp_valid, busy;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_doe;
  logic [15:0] rdata, lcd_dout;

  logic        cmd_ready1, rsp_valid1, busy1;
  logic        lcd_cs_n1, lcd_rs1, lcd_wr_n1, lcd_rd_n1, lcd_doe1;
  logic [15:0] rdata1, lcd_dout1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mlcd_bus_ctrl u0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_rs(cmd_rs), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .busy(busy),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs),
    .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
    .lcd_dout(lcd_dout), .lcd_doe(lcd_doe), .lcd_din(lcd_din)
  );

  mlcd_bus_ctrl #(
    .SETUP_CYC(1), .WR_LOW_CYC(1), .WR_HIGH_CYC(1),
    .RD_LOW_CYC(1), .RD_HIGH_CYC(1)
  ) u1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_rw(cmd_rw), .cmd_rs(cmd_rs), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid1), .rdata(rdata1), .busy(busy1),
    .lcd_cs_n(lcd_cs_n1), .lcd_rs(lcd_rs1),
    .lcd_wr_n(lcd_wr_n1), .lcd_rd_n(lcd_rd_n1),
    .lcd_dout(lcd_dout1), .lcd_doe(lcd_doe1), .lcd_din(lcd_din)
  );

  typedef struct {
    logic        rw;
    logic        rs;
    logic [15:0] wdata;
    logic [15:0] din;
    int          len;
    int          lo;
    int          lo_pos;
    logic        rsp;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int n, lo, other, pos, bad, rsps;
    n = 0; lo = 0; other = 0; pos = 0; bad = 0; rsps = 0;
    @(negedge clk);
    cmd_rw = v.rw; cmd_rs = v.rs; cmd_wdata = v.wdata;
    lcd_din = v.din; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (busy && n < 40) begin
      n++;
      if ((v.rw ? lcd_rd_n : lcd_wr_n) == 1'b0) begin
        lo++;
        if (pos == 0) pos = n;
      end
      if ((v.rw ? lcd_wr_n : lcd_rd_n) == 1'b0) other++;
      if (lcd_cs_n !== 1'b0 || lcd_rs !== v.rs) bad++;
      if (lcd_doe !== ~v.rw) bad++;
      if (!v.rw && lcd_dout !== v.wdata) bad++;
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_len", i), n, v.len);
    chk($sformatf("v%0d_strobe_lo", i), lo, v.lo);
    chk($sformatf("v%0d_strobe_pos", i), pos, v.lo_pos);
    chk($sformatf("v%0d_other_strobe", i), other, 0);
    chk($sformatf("v%0d_bus", i), bad, 0);
    chk($sformatf("v%0d_rsp_early", i), rsps, 0);
    chk($sformatf("v%0d_rsp", i), rsp_valid, v.rsp);
    chk($sformatf("v%0d_cs_idle", i), lcd_cs_n, 1);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_off", i), rsp_valid, 0);
    chk($sformatf("v%0d_rdata", i), rdata, v.rdata);
  endtask

  task automatic run_u1(input logic rw, input logic [15:0] val,
                        input string name);
    int n;
    n = 0;
    @(negedge clk);
    cmd_rw = rw; cmd_rs = 1'b1; cmd_wdata = val;
    lcd_din = val; cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    while (busy1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_len"}, n, 3);
    chk({name, "_rsp"}, rsp_valid1, rw);
    chk({name, "_ready"}, cmd_ready1, 1);
    @(negedge clk);
    chk({name, "_rsp_off"}, rsp_valid1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int phase, gap, rsps;
    logic [15:0] exp_sync;

    vecs[0] = '{1'b0, 1'b0, 16'h002C, 16'h0000, 5, 2, 2, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0000, 16'hA5C3, 7, 4, 2, 1'b1, 16'hA5C3};
    vecs[2] = '{1'b0, 1'b1, 16'hBEEF, 16'h7777, 5, 2, 2, 1'b0, 16'hA5C3};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 16'h0F0F, 7, 4, 2, 1'b1, 16'h0F0F};

    reset = 1'b1; cmd_valid = 1'b0; cmd_valid1 = 1'b0;
    cmd_rw = 1'b0; cmd_rs = 1'b0; cmd_wdata = '0; lcd_din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_strobes", {lcd_cs_n, lcd_wr_n, lcd_rd_n}, 3'b111);
    chk("rst_rs_doe", {lcd_rs, lcd_doe}, 2'b00);
    chk("rst_dout", lcd_dout, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_ready_busy", {cmd_ready, busy}, 2'b10);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
    chk("dout_hold", lcd_dout, 16'hBEEF);

    // back-to-back write then read, cmd_valid held
    @(negedge clk);
    cmd_rw = 1'b0; cmd_rs = 1'b1; cmd_wdata = 16'h3C3C;
    lcd_din = 16'h1234; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_rw = 1'b1; cmd_rs = 1'b0;
    phase = 0; gap = 0;
    for (int k = 0; k < 30; k++) begin
      if (phase == 0 && lcd_cs_n) phase = 1;
      if (phase == 1) begin
        if (lcd_cs_n) begin
          gap++;
          chk("b2b_rdata_kept", rdata, 16'h0F0F);
        end else begin
          phase = 2;
        end
      end
      if (phase == 2) cmd_valid = 1'b0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_gap", gap, 1);
    chk("b2b_rdata", rdata, 16'h1234);

    // reset in 2nd STRB_LO cycle of a read
    @(negedge clk);
    cmd_rw = 1'b1; cmd_rs = 1'b1; lcd_din = 16'h5555; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_lo", lcd_rd_n, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_strobes", {lcd_cs_n, lcd_wr_n, lcd_rd_n}, 3'b111);
    chk("abort_doe", lcd_doe, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_busy", busy, 0);
    rsps = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    chk("abort_no_rsp", rsps, 0);
    chk("abort_rdata_kept", rdata, 0);

    // sample source: din changes one cycle before STRB_LO ends
`ifdef MLCD_RD_SYNC_EN
    exp_sync = 16'h1111;
`else
    exp_sync = 16'h2222;
`endif
    @(negedge clk);
    cmd_rw = 1'b1; cmd_rs = 1'b1; lcd_din = 16'h1111; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    lcd_din = 16'h2222;
    repeat (6) @(negedge clk);
    chk("sample_src", rdata, exp_sync);

    // all parameters = 1
    run_u1(1'b0, 16'h00AA, "min_wr");
    run_u1(1'b1, 16'h6B6B, "min_rd");
    chk("min_rdata", rdata1, 16'h6B6B);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mlcd_bus_ctrl.md
MLCD_BUS_CTRL -- requirements
Module: mlcd_bus_ctrl

Upstream stage of the 16-bit MCU-LCD data-in PIO. Runs 8080-style write and read cycles on the LCD bus. Holds the read word for the PIO in_port.

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- SETUP_CYC, 1: cycles from CS/RS/data valid to strobe falling.
- WR_LOW_CYC, 2: lcd_wr_n low width.
- WR_HIGH_CYC, 2: lcd_wr_n high hold before CS release.
- RD_LOW_CYC, 4: lcd_rd_n low width.
- RD_HIGH_CYC, 2: lcd_rd_n high hold before CS release.
All five are in the range 1..255.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when cmd_valid and cmd_ready are both high.
- cmd_rw, in, 1: 0 = write, 1 = read.
- cmd_rs, in, 1: 0 = command, 1 = data.
- cmd_wdata, in, 16: write word.
- rsp_valid, out, 1: one-cycle read-done pulse.
- rdata, out, 16: last read word; drives the PIO in_port.
- busy, out, 1: transaction in progress.
- lcd_cs_n, out, 1: chip select.
- lcd_rs, out, 1: register select.
- lcd_wr_n, out, 1: write strobe.
- lcd_rd_n, out, 1: read strobe.
- lcd_dout, out, 16: bus drive value.
- lcd_doe, out, 1: bus output enable.
- lcd_din, in, 16: bus input.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, STRB_LO and STRB_HI, with one 8-bit down-counter.
REQ-005 In IDLE, cmd_ready SHALL be 1 and busy SHALL be 0; in all other states, cmd_ready SHALL be 0 and busy SHALL be 1.
REQ-006 On acceptance in IDLE, the block SHALL latch rw, rs and wdata, then enter SETUP for SETUP_CYC cycles.
REQ-007 From SETUP entry until STRB_HI exit, lcd_cs_n SHALL be 0 and lcd_rs SHALL equal the latched rs.
REQ-008 For a write, lcd_doe SHALL be 1 and lcd_dout SHALL equal the latched wdata from SETUP entry until STRB_HI exit; for a read, lcd_doe SHALL be 0 throughout.
REQ-009 In STRB_LO, the block SHALL hold lcd_wr_n (write) or lcd_rd_n (read) at 0 for WR_LOW_CYC or RD_LOW_CYC cycles; the other strobe SHALL stay 1.
REQ-010 STRB_HI SHALL last WR_HIGH_CYC or RD_HIGH_CYC cycles with both strobes at 1, then return to IDLE with lcd_cs_n = 1.
REQ-011 A write transaction SHALL occupy exactly SETUP_CYC+WR_LOW_CYC+WR_HIGH_CYC cycles of busy = 1; a read SHALL occupy SETUP_CYC+RD_LOW_CYC+RD_HIGH_CYC cycles.
REQ-012 For a read, rdata SHALL capture the sample source at the clock edge ending the last STRB_LO cycle.
REQ-013 rdata SHALL hold its value until the next read capture; writes SHALL NOT change rdata.
REQ-014 rsp_valid SHALL be 1 for exactly the first IDLE cycle after a read's STRB_HI; it SHALL never assert for writes.
REQ-015 Back-to-back commands SHALL give at least one IDLE cycle with lcd_cs_n = 1 between transactions; a command held valid SHALL be accepted in that IDLE cycle.
REQ-016 Command inputs SHALL be ignored while cmd_ready = 0.
REQ-017 lcd_dout SHALL retain its last value when lcd_doe = 0.

Reset
REQ-018 On reset, the block SHALL force these values at the next edge, including mid-transaction:
- state = IDLE;
- lcd_cs_n, lcd_wr_n and lcd_rd_n = 1;
- lcd_rs = 0, lcd_doe = 0, lcd_dout = 0;
- rdata = 0, rsp_valid = 0;
- counter = 0.
REQ-019 A transaction aborted by reset SHALL produce no rsp_valid and no rdata update.

Configuration
REQ-020 Macro MLCD_RD_SYNC_EN:
- When defined, lcd_din SHALL pass through a 2-flop synchronizer, and the sample source is stage 2, which equals lcd_din two edges earlier. RD_LOW_CYC SHALL be at least 3.
- When undefined, the sample source SHALL be lcd_din directly.
- Port list and transaction lengths SHALL be identical in both builds.

Verification
REQ-021 Write, defaults, rs = 0, wdata = 16'h002C: cs_n low 5 cycles; wr_n low cycles 2-3 of the transaction; doe = 1 and dout = 16'h002C throughout; no rsp_valid.
REQ-022 Read, defaults, lcd_din = 16'hA5C3 held: rd_n low 4 cycles; rsp_valid single pulse 7 cycles after acceptance; rdata = 16'hA5C3 until the next read.
REQ-023 Back-to-back write then read with cmd_valid held: cs_n high for exactly 1 cycle between them; the write does not disturb the prior rdata.
REQ-024 Reset asserted in the 2nd STRB_LO cycle of a read: the next cycle shows all strobes = 1, cs_n = 1, doe = 0, rdata = 0, and no rsp_valid.
REQ-025 MLCD_RD_SYNC_EN defined, lcd_din changes from 16'h1111 to 16'h2222 one cycle before the end of STRB_LO: rdata = 16'h1111.
REQ-026 All parameters = 1: write lasts 3 cycles, read lasts 3 cycles; rsp_valid and cmd_ready timing match REQ-011, REQ-014 and REQ-015.
